// File: rtl/next_pc_gen_pkg.sv
// Shared constants and types for the fetch-stage next-PC generator.
package next_pc_gen_pkg;

  localparam logic [1:0] BTYPE_NUL = 2'b00;
  localparam logic [1:0] BTYPE_CAL = 2'b01;
  localparam logic [1:0] BTYPE_RET = 2'b10;
  localparam logic [1:0] BTYPE_ABS = 2'b11;

  localparam int unsigned DEFAULT_RAS_DEPTH = 8;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'hBFC0_0000;

  typedef enum logic [0:0] {
    StSeq,
    StDslot
  } fetch_state_e;

endpackage

// File: rtl/next_pc_gen_if.sv
// Bundle between the fetch control / BTB side and the next-PC generator.
interface next_pc_gen_if #(
  parameter int unsigned RAS_DEPTH = 8
);
  localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

  logic          stall;
  logic          hit0;
  logic [1:0]    predict_type0;
  logic [31:0]   predict_tar0;
  logic          redirect_valid;
  logic [31:0]   redirect_tar;
  logic          flush;
  logic [31:0]   flush_tar;
  logic [31:0]   pc;
  logic [31:0]   pc_p4;
  logic          pred_taken;
  logic [31:0]   pred_tar;
  logic [CW-1:0] ras_count;

  modport master (
    output stall, hit0, predict_type0, predict_tar0,
    output redirect_valid, redirect_tar, flush, flush_tar,
    input  pc, pc_p4, pred_taken, pred_tar, ras_count
  );

  modport slave (
    input  stall, hit0, predict_type0, predict_tar0,
    input  redirect_valid, redirect_tar, flush, flush_tar,
    output pc, pc_p4, pred_taken, pred_tar, ras_count
  );

endinterface

// File: rtl/next_pc_gen_return_addr_stack.sv
// Circular return-address stack: pushes past full overwrite the oldest entry,
// count saturates at Depth, pointer wraps in both directions.
module return_addr_stack #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [Width-1:0]         push_data,
  output logic [Width-1:0]         top,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PW = $clog2(Depth);
  localparam int unsigned CW = PW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PW-1:0]    ptr_q;
  logic [CW-1:0]    count_q;
  logic [PW-1:0]    top_idx;

  // ptr_q is the next write slot, so the top entry sits one below it.
  assign top_idx = ptr_q - PW'(1);
  assign top     = mem_q[top_idx];
  assign count   = count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (push) begin
      mem_q[ptr_q] <= push_data;
      ptr_q        <= ptr_q + PW'(1);
      if (count_q != CW'(Depth)) begin
        count_q <= count_q + CW'(1);
      end
    end else if (pop) begin
      ptr_q <= ptr_q - PW'(1);
      if (count_q != '0) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/next_pc_gen.sv
// Fetch next-PC generator: delay-slot sequencing of BTB predictions, RAS-based
// return prediction, and flush/redirect override from later stages.
module next_pc_gen
  import next_pc_gen_pkg::*;
#(
  parameter int unsigned RAS_DEPTH = DEFAULT_RAS_DEPTH,
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        resetn,
  next_pc_gen_if.slave fe
);

  localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   pc_p4_q;
  logic [31:0]   tar_q, tar_d;

  logic          seq_adv;
  logic          taken;
  logic [31:0]   tar_seq;
  logic          ras_push, ras_pop, ras_clear;
  logic [31:0]   ras_top;
  logic [CW-1:0] ras_cnt;

  return_addr_stack #(
    .Depth (RAS_DEPTH),
    .Width (32)
  ) u_ras (
    .clk       (clk),
    .resetn    (resetn),
    .push      (ras_push),
    .pop       (ras_pop),
    .clear     (ras_clear),
    .push_data (pc_q + 32'd8),
    .top       (ras_top),
    .count     (ras_cnt)
  );

  // Prediction decode for the current SEQ fetch; RET with an empty RAS falls through.
  always_comb begin
    taken   = 1'b0;
    tar_seq = fe.predict_tar0;
    if (fe.hit0) begin
      case (fe.predict_type0)
        BTYPE_RET: begin
          if (ras_cnt != '0) begin
            taken   = 1'b1;
            tar_seq = ras_top;
          end
        end
        default: taken = 1'b1;
      endcase
    end
  end

  assign seq_adv   = !fe.flush && !fe.redirect_valid && !fe.stall && (state_q == StSeq);
  assign ras_push  = seq_adv && fe.hit0 && (fe.predict_type0 == BTYPE_CAL);
  assign ras_pop   = seq_adv && taken && (fe.predict_type0 == BTYPE_RET);
  assign ras_clear = fe.flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StSeq;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (fe.flush || fe.redirect_valid) begin
      state_d = StSeq;
    end else if (!fe.stall) begin
      unique case (state_q)
        StSeq:   if (taken) state_d = StDslot;
        StDslot: state_d = StSeq;
        default: state_d = StSeq;
      endcase
    end
  end

  always_comb begin
    fe.pc         = pc_q;
    fe.pc_p4      = pc_p4_q;
    fe.pred_taken = (state_q == StDslot);
    fe.pred_tar   = (state_q == StDslot) ? tar_q : 32'd0;
    fe.ras_count  = ras_cnt;
  end

  always_comb begin
    pc_d  = pc_q;
    tar_d = tar_q;
    if (fe.flush) begin
      pc_d  = fe.flush_tar;
      tar_d = 32'd0;
    end else if (fe.redirect_valid) begin
      pc_d  = fe.redirect_tar;
      tar_d = 32'd0;
    end else if (!fe.stall) begin
      if (state_q == StDslot) begin
        pc_d  = tar_q;
        tar_d = 32'd0;
      end else begin
        pc_d = pc_q + 32'd4;
        if (taken) begin
          tar_d = tar_seq;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q    <= RESET_PC;
      pc_p4_q <= RESET_PC + 32'd4;
      tar_q   <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      pc_p4_q <= pc_d + 32'd4;
      tar_q   <= tar_d;
    end
  end

endmodule

// File: doc/next_pc_gen.md
# next_pc_gen

Fetch-stage next-PC generator that drives `pc`/`pc_p4` into `branch_target_buffer` and the I-cache, and consumes the BTB's same-cycle `hit0`/`predict_type0`/`predict_tar0` verdict. It does three jobs:
- Sequences MIPS delay slots: a predicted-taken fetch is followed by the delay-slot fetch, then the target.
- Keeps a return-address stack (RAS) for call/return prediction.
- Applies flush and mispredict redirects from later stages.

## Interface
- `RAS_DEPTH`, 8: RAS entries; power of two, ≥2.
- `RESET_PC`, 32'hBFC0_0000: PC after reset.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `resetn` in 1: reset, **asynchronous, active-low**.
- `stall` in 1: hold PC, FSM and RAS.
- `hit0` in 1: BTB hit for current `pc`.
- `predict_type0` in 2: BTB branch type for current `pc`.
- `predict_tar0` in 32: BTB target for current `pc`.
- `redirect_valid` in 1: mispredict correction from ID.
- `redirect_tar` in 32: corrected next fetch PC.
- `flush` in 1: exception/ERET flush.
- `flush_tar` in 32: flush fetch PC.
- `pc` out 32: current fetch PC, registered.
- `pc_p4` out 32: registered. Always equals `pc`+4.
- `pred_taken` out 1: high while the current fetch is the delay slot of a predicted-taken branch.
- `pred_tar` out 32: target that will be fetched after that delay slot.
- `ras_count` out $clog2(RAS_DEPTH)+1: valid RAS entries.

## Operation
- The FSM has two states:
  - SEQ: normal sequential fetch.
  - DSLOT: fetching the delay slot; a target is pending.
- Next-PC priority (highest first): `flush` > `redirect_valid` > `stall` > prediction.
- `flush`:
  - `pc`←`flush_tar`; state→SEQ; RAS emptied (count 0, top pointer 0); `pred_taken`←0.
  - Applied even when `stall`=1.
- `redirect_valid`:
  - `pc`←`redirect_tar`; state→SEQ; `pred_taken`←0; RAS untouched.
  - Applied even when `stall`=1.
- `stall` (with no flush/redirect): every register holds.
- SEQ, `hit0`=0: `pc`←`pc`+4.
- SEQ, `hit0`=1, type `BTYPE_CAL`:
  - Push `pc`+8 onto the RAS.
  - Pending target←`predict_tar0`.
  - `pc`←`pc`+4; state→DSLOT.
- SEQ, `hit0`=1, type `BTYPE_RET`:
  - If `ras_count`>0: pending target←RAS top; pop; `pc`←`pc`+4; →DSLOT.
  - If `ras_count`=0: treated as not-taken; `pc`←`pc`+4; stay SEQ.
- SEQ, `hit0`=1, type `BTYPE_NUL` or `BTYPE_ABS`: pending target←`predict_tar0`; `pc`←`pc`+4; →DSLOT.
- DSLOT:
  - `pc`←pending target; →SEQ.
  - `hit0` is ignored, since a branch in a delay slot is illegal.
- `pred_taken`=1 exactly while in DSLOT. `pred_tar` = pending target (0 otherwise).
- RAS behaviour:
  - Circular buffer; the top pointer wraps modulo `RAS_DEPTH`.
  - Push when full overwrites the oldest entry; count saturates at `RAS_DEPTH`.
  - Pop wraps the pointer downward.
- Arithmetic is 32-bit, wrapping at 2^32; no overflow detection.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `pc_p4`=`RESET_PC`+4.
  - `pred_taken`=0, `pred_tar`=0, `ras_count`=0, state SEQ.
  - All RAS entries 0.
- BTB lookup is combinational on `pc` within the cycle; the next PC is registered at the following edge.
- Predicted-taken branch at A fetched in cycle n:
  - `pc`=A+4 in n+1.
  - `pc`=target in n+2 (one-cycle delay-slot latency, no bubble).
- A push or pop commits at the same edge that leaves SEQ. The RAS top read in cycle n is the value before that edge's update.
- Redirect/flush in cycle n gives the new `pc` in n+1 and cancels any pending DSLOT target.
- Stall in DSLOT holds DSLOT and the pending target until released.
- Reset may be asserted at any time: all state returns to reset values immediately (asynchronous).

## Structure
- `defines.v` holds the shared constants `BTYPE_NUL`=2'b00, `BTYPE_CAL`=2'b01, `BTYPE_RET`=2'b10, `BTYPE_ABS`=2'b11, plus `RESET_PC` and the RAS depth.
- One sub-module, `return_addr_stack`:
  - Inputs: push, pop, push data, clear.
  - Outputs: top, count.
  - Contains the wrap and saturation logic.
- The FSM and next-PC mux live in `next_pc_gen`.

## Test plan
- **Reset/sequential:** release reset with no hits → `pc` = BFC00000, BFC00004, BFC00008; `pc_p4` always `pc`+4.
- **Call/return:** `hit0` with CAL at 0x100 (target 0x400) → `pc` 0x104 then 0x400, `ras_count`=1. Later RET hit at 0x500 → `pc` 0x504 then 0x108, `ras_count`=0.
- **RAS overflow/underflow:** 9 calls with depth 8 → `ras_count` stays 8 and the oldest return address is lost. 9 returns → the first 8 predict pushes 9..2 in reverse order; the 9th falls through to `pc`+4.
- **Redirect in DSLOT:** `redirect_valid` with `redirect_tar`=0x2000 during DSLOT → `pc`=0x2000 next cycle, pending target discarded, `pred_taken`=0.
- **Stall vs flush:** `stall` held 3 cycles in DSLOT → `pc`/`pred_tar` frozen. `flush`=1 with `flush_tar`=0xBFC00380 while stalled → `pc`=0xBFC00380 next cycle, `ras_count`=0.
- **Asynchronous reset:** drop `resetn` mid-cycle in DSLOT → outputs reach reset values before the next edge.
